dmem_responder: RTL

// - Data-memory responder for the mips core's load/store port; the core is the initiator, this block is the target.
// - Accepts one request at a time over a valid/ready handshake.
// - Inserts LATENCY programmable wait states, then returns a single-cycle response.
// - Lets the core's stall logic be exercised against a non-zero-latency memory in simulation.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_ram.sv | 34 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and range helper for the data-memory responder
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when no address bit above the word-index field is set.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int unsigned addr_w);
        logic [WORD_W-1:0] hi;
        hi = addr >> (addr_w + 2);
        return (hi == '0);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the core load/store port and the responder
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, synchronous read, per-byte write enable, no reset
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - one-at-a-time memory target with programmable wait states before a one-cycle response
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              lat_we_q, lat_we_d;
    logic              lat_ok_q, lat_ok_d;
    logic [ADDR_W-1:0] lat_idx_q, lat_idx_d;
    logic [BE_W-1:0]   lat_be_q, lat_be_d;
    logic [WORD_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_en_q, rd_en_d;

    logic              accept;
    logic              live_ok;
    logic              enter_resp;
    logic              use_live;
    logic              eff_we;
    logic              eff_ok;
    logic [ADDR_W-1:0] eff_idx;
    logic [BE_W-1:0]   eff_be;
    logic [WORD_W-1:0] eff_wdata;
    logic              ram_en;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_ok_d    = lat_ok_q;
        lat_idx_d   = lat_idx_q;
        lat_be_d    = lat_be_q;
        lat_wdata_d = lat_wdata_q;

        accept  = (state_q == IDLE) && bus.req_valid && req_ready_q;
        live_ok = addr_in_range(bus.req_addr, ADDR_W);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    lat_we_d    = bus.req_we;
                    lat_ok_d    = live_ok;
                    lat_idx_d   = bus.req_addr[ADDR_W+1:2];
                    lat_be_d    = bus.req_be;
                    lat_wdata_d = bus.req_wdata;
                    cnt_d       = LAT4;
                    state_d     = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // With zero latency the RAM access happens on the accept edge itself,
        // before the latch holds the request, so the live inputs are used.
        use_live  = (state_q == IDLE);
        eff_we    = use_live ? bus.req_we                  : lat_we_q;
        eff_ok    = use_live ? live_ok                     : lat_ok_q;
        eff_idx   = use_live ? bus.req_addr[ADDR_W+1:2]    : lat_idx_q;
        eff_be    = use_live ? bus.req_be                  : lat_be_q;
        eff_wdata = use_live ? bus.req_wdata               : lat_wdata_q;

        enter_resp = (state_d == RESP);
        ram_en     = enter_resp && !rst;
        ram_we     = eff_we && eff_ok;

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = enter_resp;
        rsp_err_d   = enter_resp && !eff_ok;
        rd_en_d     = enter_resp && !eff_we && eff_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_ok_q    <= 1'b0;
            lat_idx_q   <= '0;
            lat_be_q    <= '0;
            lat_wdata_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_ok_q    <= lat_ok_d;
            lat_idx_q   <= lat_idx_d;
            lat_be_q    <= lat_be_d;
            lat_wdata_q <= lat_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_en_q     <= rd_en_d;
        end
    end

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (eff_be),
        .addr  (eff_idx),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_en_q ? ram_rdata : '0;

endmodule
